// File: rtl/dds_tone_sequencer.sv
// Tone-list player that feeds the dds frequency input. It walks a small table of
// (frequency, duration) entries, optionally looping, with gapless entry changes.
module dds_tone_sequencer #(
  parameter int DEPTH  = 8,
  parameter int FREQ_W = 32,
  parameter int DUR_W  = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [$clog2(DEPTH)-1:0]  wr_addr,
  input  logic [FREQ_W-1:0]         wr_freq,
  input  logic [DUR_W-1:0]          wr_dur,
  input  logic [$clog2(DEPTH):0]    len,
  input  logic                      loop,
  input  logic                      start,
  input  logic                      stop,
  output logic [FREQ_W-1:0]         freq_out,
  output logic                      tone_en,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(DEPTH)-1:0]  cur_idx
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [FREQ_W-1:0]   tbl_freq_r [DEPTH];
  logic [DUR_W-1:0]    tbl_dur_r  [DEPTH];
  logic [AW:0]         len_r, len_s;
  logic                loop_r, loop_s;
  logic [AW-1:0]       idx_r, idx_s;
  logic [DUR_W-1:0]    cnt_r, cnt_s;
  logic [FREQ_W-1:0]   freq_r, freq_s;
  logic                tone_r, tone_s;
  logic                done_r, done_s;
  logic [AW-1:0]       cur_r, cur_s;
  logic                load_s;
  logic [AW-1:0]       load_idx_s;
  logic [AW:0]         len_clip_s;

  // Tone table storage; deliberately not reset so a program survives rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl_freq_r[wr_addr] <= wr_freq;
      tbl_dur_r[wr_addr]  <= wr_dur;
    end
  end

  // Next-state and datapath decisions for the playback FSM.
  always_comb begin
    state_s    = state_r;
    len_s      = len_r;
    loop_s     = loop_r;
    idx_s      = idx_r;
    cnt_s      = cnt_r;
    freq_s     = freq_r;
    tone_s     = tone_r;
    done_s     = 1'b0;
    cur_s      = cur_r;
    load_s     = 1'b0;
    load_idx_s = idx_r;
    len_clip_s = (len > DEPTH_L) ? DEPTH_L : len;

    case (state_r)
      S_IDLE: begin
        if (start && !stop) begin
          len_s  = len_clip_s;
          loop_s = loop;
          idx_s  = '0;
          if (len_clip_s == '0) begin
            done_s = 1'b1;
          end else begin
            state_s = S_LOAD;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (stop) begin
          state_s = S_IDLE;
          tone_s  = 1'b0;
        end else begin
          load_s     = 1'b1;
          load_idx_s = '0;
          state_s    = S_PLAY;
        end
      end
      S_PLAY: begin
        if (stop) begin
          state_s = S_IDLE;
          tone_s  = 1'b0;
        end else if (cnt_r != '0) begin
          cnt_s = cnt_r - DUR_W'(1);
        end else if (({1'b0, idx_r} + (AW+1)'(1)) < len_r) begin
          load_s     = 1'b1;
          load_idx_s = idx_r + AW'(1);
        end else if (loop_r) begin
          load_s     = 1'b1;
          load_idx_s = '0;
        end else begin
          tone_s  = 1'b0;
          done_s  = 1'b1;
          state_s = S_IDLE;
        end
      end
      default: begin
        state_s = S_IDLE;
        tone_s  = 1'b0;
      end
    endcase

    // A load replaces the running entry in the same edge, so there is no silent gap.
    if (load_s) begin
      idx_s  = load_idx_s;
      cur_s  = load_idx_s;
      freq_s = tbl_freq_r[load_idx_s];
      cnt_s  = (tbl_dur_r[load_idx_s] == '0) ? '0 : tbl_dur_r[load_idx_s] - DUR_W'(1);
      tone_s = 1'b1;
    end else begin
      cur_s = cur_r;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      len_r   <= '0;
      loop_r  <= 1'b0;
      idx_r   <= '0;
      cnt_r   <= '0;
      freq_r  <= '0;
      tone_r  <= 1'b0;
      done_r  <= 1'b0;
      cur_r   <= '0;
    end else begin
      state_r <= state_s;
      len_r   <= len_s;
      loop_r  <= loop_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
      freq_r  <= freq_s;
      tone_r  <= tone_s;
      done_r  <= done_s;
      cur_r   <= cur_s;
    end
  end

  assign freq_out = freq_r;
  assign tone_en  = tone_r;
  assign done     = done_r;
  assign cur_idx  = cur_r;
  assign busy     = (state_r != S_IDLE);

endmodule

// File: tb/tb_dds_tone_sequencer.sv
// Directed bench for dds_tone_sequencer: hand-computed tone sequences,
// looping, zero durations, stop, reset retention and live table writes.
module tb_dds_tone_sequencer;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_freq;
  logic [23:0] wr_dur;
  logic [3:0]  len;
  logic        loop;
  logic        start;
  logic        stop;
  logic [31:0] freq_out;
  logic        tone_en;
  logic        busy;
  logic        done;
  logic [2:0]  cur_idx;

  int n_tests;
  int n_fail;

  dds_tone_sequencer #(.DEPTH(8), .FREQ_W(32), .DUR_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_freq(wr_freq), .wr_dur(wr_dur), .len(len), .loop(loop),
    .start(start), .stop(stop), .freq_out(freq_out), .tone_en(tone_en),
    .busy(busy), .done(done), .cur_idx(cur_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [31:0] f, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_freq = f; wr_dur = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Start a run and step through the one-cycle LOAD state.
  task automatic kick(input logic [3:0] l, input logic lp);
    len = l; loop = lp; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_in_load", 32'(busy), 32'(1));
    check("tone_in_load", 32'(tone_en), 32'(0));
    tick();
  endtask

  // Expect one entry held for n cycles, then move to the next entry.
  task automatic expect_tone(input string tag, input logic [31:0] f, input int n, input logic [2:0] i);
    for (int k = 0; k < n; k++) begin
      check({tag, "_freq"}, freq_out, f);
      check({tag, "_tone"}, 32'(tone_en), 32'(1));
      check({tag, "_idx"},  32'(cur_idx), 32'(i));
      check({tag, "_done"}, 32'(done), 32'(0));
      check({tag, "_busy"}, 32'(busy), 32'(1));
      tick();
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] f, input logic t,
                               input logic b, input logic d, input logic [2:0] i);
    check({tag, "_freq"}, freq_out, f);
    check({tag, "_tone"}, 32'(tone_en), 32'(t));
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_idx"},  32'(cur_idx), 32'(i));
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_freq = 32'd0; wr_dur = 24'd0;
    len = 4'd0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    tick(); tick();
    check_outputs("reset", 32'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    rst_n = 1'b1;

    // 1: two entries, single pass
    write_entry(3'd0, 32'd1000, 24'd4);
    write_entry(3'd1, 32'd2000, 24'd2);
    kick(4'd2, 1'b0);
    expect_tone("t1_e0", 32'd1000, 4, 3'd0);
    expect_tone("t1_e1", 32'd2000, 2, 3'd1);
    check_outputs("t1_end", 32'd2000, 1'b0, 1'b0, 1'b1, 3'd1);
    tick();
    check_outputs("t1_after", 32'd2000, 1'b0, 1'b0, 1'b0, 3'd1);

    // 2: loop three times, then stop
    kick(4'd2, 1'b1);
    for (int r = 0; r < 3; r++) begin
      expect_tone("t2_e0", 32'd1000, 4, 3'd0);
      expect_tone("t2_e1", 32'd2000, 2, 3'd1);
    end
    check("t2_wrap_freq", freq_out, 32'd1000);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_outputs("t2_stop", 32'd1000, 1'b0, 1'b0, 1'b0, 3'd0);

    // 3: zero duration held exactly one cycle
    write_entry(3'd0, 32'd100, 24'd3);
    write_entry(3'd1, 32'd200, 24'd0);
    write_entry(3'd2, 32'd300, 24'd3);
    kick(4'd3, 1'b0);
    expect_tone("t3_e0", 32'd100, 3, 3'd0);
    expect_tone("t3_e1", 32'd200, 1, 3'd1);
    expect_tone("t3_e2", 32'd300, 3, 3'd2);
    check_outputs("t3_end", 32'd300, 1'b0, 1'b0, 1'b1, 3'd2);
    tick();

    // 4: len=0 gives an immediate done without a tone
    len = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check_outputs("t4_done", 32'd300, 1'b0, 1'b0, 1'b1, 3'd2);
    tick();
    check_outputs("t4_after", 32'd300, 1'b0, 1'b0, 1'b0, 3'd2);

    // 5: stop and start together mid-run, then replay
    kick(4'd3, 1'b0);
    expect_tone("t5_e0", 32'd100, 2, 3'd0);
    stop = 1'b1; start = 1'b1;
    tick();
    check_outputs("t5_stop", 32'd100, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    stop = 1'b0; start = 1'b0;
    check_outputs("t5_stay", 32'd100, 1'b0, 1'b0, 1'b0, 3'd0);
    kick(4'd3, 1'b0);
    expect_tone("t5_re0", 32'd100, 3, 3'd0);
    check("t5_re1_freq", freq_out, 32'd200);

    // 6: reset mid-play, table retained, plus a write during playback
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_outputs("t6_reset", 32'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    kick(4'd3, 1'b0);
    check("t6_e0_freq", freq_out, 32'd100);
    wr_en = 1'b1; wr_addr = 3'd1; wr_freq = 32'd250; wr_dur = 24'd2;
    tick();
    wr_en = 1'b0;
    expect_tone("t6_e0", 32'd100, 2, 3'd0);
    expect_tone("t6_e1", 32'd250, 2, 3'd1);
    expect_tone("t6_e2", 32'd300, 3, 3'd2);
    check_outputs("t6_end", 32'd300, 1'b0, 1'b0, 1'b1, 3'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
